// File: rtl/ro_freq_meas_pkg.sv
// Shared types and defaults for the ring-oscillator frequency measurement block.
// Optional glitch filter controlled by RO_FREQ_MEAS_DEGLITCH_EN (see ro_freq_meas_sync).
package ro_freq_meas_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int WIN_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEGLITCH_TAPS   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic logic maj3(input logic [DEGLITCH_TAPS-1:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/ro_freq_meas_sync.sv
// RO_IN synchroniser and rising-edge detector.
// With RO_FREQ_MEAS_DEGLITCH_EN defined, a 3-sample majority filter sits before the edge detector.
module ro_freq_meas_sync
    import ro_freq_meas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic RO_IN,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   prev_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RO_IN};
        end
    end

`ifdef RO_FREQ_MEAS_DEGLITCH_EN
    // Two history taps plus the live sync output form the majority window.
    logic [DEGLITCH_TAPS-2:0] hist_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[DEGLITCH_TAPS-3:0], sync_q[SYNC_STAGES-1]};
        end
    end

    assign lvl = maj3({hist_q, sync_q[SYNC_STAGES-1]});
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign rise = lvl & ~prev_q;

endmodule

// File: rtl/ro_freq_meas.sv
// Ring-oscillator frequency measurement: counts RO_IN rising edges over a WINDOW-cycle gate.
// Build option RO_FREQ_MEAS_DEGLITCH_EN enables the majority glitch filter in the synchroniser.
//
// state    | meaning
// IDLE     | waiting for START; COUNT/OVF keep the last result
// COUNT    | gate open, window counter running, edges accumulated
// HOLD     | result presented with RES_VALID until RES_READY
module ro_freq_meas
    import ro_freq_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RO_IN,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    output logic             BUSY,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_COUNT = ST_COUNT;
    localparam logic [1:0] S_HOLD  = ST_HOLD;

    logic [1:0]       state_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             busy_q;
    logic             valid_q;
    logic             rise;

    ro_freq_meas_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .RO_IN(RO_IN),
        .rise (rise)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        win_q  <= WINDOW;
                        cnt_q  <= '0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (WINDOW != '0) begin
                            state_q <= S_COUNT;
                        end else begin
                            state_q <= S_HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_COUNT: begin
                    win_q <= win_q - 1'b1;
                    // Saturate rather than wrap; the first lost edge flags overflow.
                    if (rise) begin
                        if (cnt_q == '1) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    if (win_q == WIN_W'(1)) begin
                        state_q <= S_HOLD;
                        valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (RES_READY) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign RES_VALID = valid_q;
    assign COUNT     = cnt_q;
    assign OVF       = ovf_q;

endmodule
